exec_stage: RTL

// Execute stage fed by the decode/execute pipeline register; registers results into the E/M boundary.
// - ALU with operand-B select, NZCV flag register, branch/jump resolution.
// - Iterative multi-cycle multiplier that stalls the front end while it runs.
// - Drives pcsrc/target to fetch and flush_E back to the decode/execute register.

---
 rtl/exec_stage.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_stage.sv
// Execute stage: ALU, NZCV flags, branch/jump resolution and E/M pipeline register.
// Defining EXEC_MUL_EN adds an iterative shift-add multiplier (op 8) that stalls the front end.
module exec_stage #(
   parameter int N = 32,
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pcload_E,
   input  logic         regw_E,
   input  logic         memw_E,
   input  logic         regmem_E,
   input  logic         branch_E,
   input  logic         ALUope_E,
   input  logic         flag_E,
   input  logic [M-1:0] ALUctrl_E,
   input  logic [M-1:0] regScr_E,
   input  logic [N-1:0] inm_E,
   input  logic [N-1:0] regA_E,
   input  logic [N-1:0] regB_E,
   output logic [N-1:0] res_M,
   output logic [N-1:0] wdata_M,
   output logic [M-1:0] regScr_M,
   output logic         regw_M,
   output logic         memw_M,
   output logic         regmem_M,
   output logic [3:0]   flags,
   output logic         pcsrc_E,
   output logic [N-1:0] target_E,
   output logic         flush_E,
   output logic         stall_E
);

   localparam logic [M-1:0] OP_ADD = M'(0);
   localparam logic [M-1:0] OP_SUB = M'(1);
   localparam logic [M-1:0] OP_AND = M'(2);
   localparam logic [M-1:0] OP_OR  = M'(3);
   localparam logic [M-1:0] OP_XOR = M'(4);
   localparam logic [M-1:0] OP_SLL = M'(5);
   localparam logic [M-1:0] OP_SRL = M'(6);
   localparam logic [M-1:0] OP_CMP = M'(7);
   localparam logic [M-1:0] OP_MOV = M'(9);

   logic [N-1:0] opb;
   logic [N-1:0] alu_res;
   logic [N:0]   sum_ext;
   logic [N:0]   dif_ext;
   logic         alu_c;
   logic         alu_v;
   logic         add_v;
   logic         sub_v;
   logic [4:0]   shamt;
   logic         cond_ok;
   logic         is_jump;
   logic         front_idle;

   logic [N-1:0] res_q, res_d;
   logic [N-1:0] wdata_q, wdata_d;
   logic [M-1:0] rd_q, rd_d;
   logic         regw_q, regw_d;
   logic         memw_q, memw_d;
   logic         regmem_q, regmem_d;
   logic [3:0]   flags_q, flags_d;

   assign opb     = ALUope_E ? inm_E : regB_E;
   assign sum_ext = {1'b0, regA_E} + {1'b0, opb};
   assign dif_ext = {1'b0, regA_E} - {1'b0, opb};
   assign add_v   = (regA_E[N-1] == opb[N-1]) && (sum_ext[N-1] != regA_E[N-1]);
   assign sub_v   = (regA_E[N-1] != opb[N-1]) && (dif_ext[N-1] != regA_E[N-1]);
   assign shamt   = opb[4:0];
   assign is_jump = pcload_E || branch_E;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (ALUctrl_E)
         OP_ADD: begin
            alu_res = sum_ext[N-1:0];
            alu_c   = sum_ext[N];
            alu_v   = add_v;
         end
         OP_SUB, OP_CMP: begin
            alu_res = dif_ext[N-1:0];
            alu_c   = ~dif_ext[N];
            alu_v   = sub_v;
         end
         OP_AND:  alu_res = regA_E & opb;
         OP_OR:   alu_res = regA_E | opb;
         OP_XOR:  alu_res = regA_E ^ opb;
         OP_SLL:  alu_res = regA_E << shamt;
         OP_SRL:  alu_res = regA_E >> shamt;
         OP_MOV:  alu_res = opb;
         default: alu_res = '0;
      endcase
   end

   // Conditions read the flags register as it stood before this edge.
   always_comb begin
      case (ALUctrl_E)
         M'(0):   cond_ok = 1'b1;
         M'(1):   cond_ok = flags_q[2];
         M'(2):   cond_ok = ~flags_q[2];
         M'(3):   cond_ok = flags_q[3] ^ flags_q[0];
         default: cond_ok = 1'b0;
      endcase
   end

   assign pcsrc_E  = front_idle && (pcload_E || (branch_E && cond_ok));
   assign flush_E  = pcsrc_E;
   assign target_E = pcload_E ? regA_E : regA_E + inm_E;

`ifdef EXEC_MUL_EN
   localparam logic [M-1:0] OP_MUL = M'(8);
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

   mul_state_t   state_q, state_d;
   logic [N-1:0] mcand_q, mcand_d;
   logic [N-1:0] mplier_q, mplier_d;
   logic [N-1:0] acc_q, acc_d;
   logic [CW-1:0] count_q, count_d;
   logic [N-1:0] mwdata_q, mwdata_d;
   logic [M-1:0] mrd_q, mrd_d;
   logic         mregw_q, mregw_d;
   logic         mmemw_q, mmemw_d;
   logic         mregmem_q, mregmem_d;
   logic         mflag_q, mflag_d;
   logic         is_mul;
   logic [N-1:0] mul_prod;

   assign is_mul     = (ALUctrl_E == OP_MUL) && !is_jump;
   assign front_idle = (state_q == IDLE);
   assign stall_E    = (front_idle && is_mul) || (state_q == BUSY);
   // BUSY covers multiplier bits 0..N-2; the top bit is folded in during DONE.
   assign mul_prod   = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
   assign front_idle = 1'b1;
   assign stall_E    = 1'b0;
`endif

   always_comb begin
      res_d    = alu_res;
      wdata_d  = regB_E;
      rd_d     = regScr_E;
      regw_d   = regw_E && (ALUctrl_E != OP_CMP);
      memw_d   = memw_E;
      regmem_d = regmem_E;
      flags_d  = flag_E ? {alu_res[N-1], alu_res == '0, alu_c, alu_v} : flags_q;
      if (is_jump) begin
         res_d    = '0;
         regw_d   = 1'b0;
         memw_d   = 1'b0;
         regmem_d = 1'b0;
         flags_d  = flags_q;
      end
`ifdef EXEC_MUL_EN
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      count_d   = count_q;
      mwdata_d  = mwdata_q;
      mrd_d     = mrd_q;
      mregw_d   = mregw_q;
      mmemw_d   = mmemw_q;
      mregmem_d = mregmem_q;
      mflag_d   = mflag_q;
      if ((state_q == BUSY) || (state_q == IDLE && is_mul)) begin
         res_d    = '0;
         wdata_d  = '0;
         rd_d     = '0;
         regw_d   = 1'b0;
         memw_d   = 1'b0;
         regmem_d = 1'b0;
         flags_d  = flags_q;
      end
      case (state_q)
         IDLE: begin
            if (is_mul) begin
               state_d   = BUSY;
               mcand_d   = regA_E;
               mplier_d  = opb;
               acc_d     = '0;
               count_d   = '0;
               mwdata_d  = regB_E;
               mrd_d     = regScr_E;
               mregw_d   = regw_E;
               mmemw_d   = memw_E;
               mregmem_d = regmem_E;
               mflag_d   = flag_E;
            end
         end
         BUSY: begin
            acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if (count_q == CW'(N - 2)) state_d = DONE;
         end
         DONE: begin
            state_d  = IDLE;
            res_d    = mul_prod;
            wdata_d  = mwdata_q;
            rd_d     = mrd_q;
            regw_d   = mregw_q;
            memw_d   = mmemw_q;
            regmem_d = mregmem_q;
            flags_d  = mflag_q ? {mul_prod[N-1], mul_prod == '0, 2'b00} : flags_q;
         end
         default: state_d = IDLE;
      endcase
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_q     <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         regw_q    <= 1'b0;
         memw_q    <= 1'b0;
         regmem_q  <= 1'b0;
         flags_q   <= 4'b0000;
`ifdef EXEC_MUL_EN
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         mwdata_q  <= '0;
         mrd_q     <= '0;
         mregw_q   <= 1'b0;
         mmemw_q   <= 1'b0;
         mregmem_q <= 1'b0;
         mflag_q   <= 1'b0;
`endif
      end else begin
         res_q     <= res_d;
         wdata_q   <= wdata_d;
         rd_q      <= rd_d;
         regw_q    <= regw_d;
         memw_q    <= memw_d;
         regmem_q  <= regmem_d;
         flags_q   <= flags_d;
`ifdef EXEC_MUL_EN
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         mwdata_q  <= mwdata_d;
         mrd_q     <= mrd_d;
         mregw_q   <= mregw_d;
         mmemw_q   <= mmemw_d;
         mregmem_q <= mregmem_d;
         mflag_q   <= mflag_d;
`endif
      end
   end

   assign res_M    = res_q;
   assign wdata_M  = wdata_q;
   assign regScr_M = rd_q;
   assign regw_M   = regw_q;
   assign memw_M   = memw_q;
   assign regmem_M = regmem_q;
   assign flags    = flags_q;

endmodule
